// File: rtl/ball_ctrl_if.sv
// Signal bundle between the game stimulus/brick side and the ball controller.
interface ball_ctrl_if;
  logic        tick;
  logic        launch;
  logic [10:0] paddle_h;
  logic [23:0] arr;
  logic [10:0] bh_pos;
  logic [10:0] bv_pos;
  logic        bdirect_h;
  logic        bdirect_v;
  logic [1:0]  lives;
  logic        brick_hit;
  logic        game_over;
  logic        win;

  modport master (
    output tick, launch, paddle_h, arr,
    input  bh_pos, bv_pos, bdirect_h, bdirect_v, lives, brick_hit, game_over, win
  );

  modport slave (
    input  tick, launch, paddle_h, arr,
    output bh_pos, bv_pos, bdirect_h, bdirect_v, lives, brick_hit, game_over, win
  );
endinterface

// File: rtl/ball_ctrl.sv
// Breakout ball controller: serve, motion with wall/paddle/brick bounces, lives and end states.
module ball_ctrl #(
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_Y    = 16,
  parameter int START_LIVES = 3
) (
  input logic        clk,
  input logic        rst,
  ball_ctrl_if.slave bus
);

  typedef enum logic [2:0] {SERVE, MOVE, CHECK, LOST, GAMEOVER, WIN} state_t;

  localparam logic [10:0] REST_V   = 11'(PADDLE_Y + 1);
  localparam logic [10:0] LIFT_V   = 11'(PADDLE_Y + 2);
  localparam logic [10:0] HALF_W   = 11'(PADDLE_W / 2);
  localparam logic [11:0] PAD_SPAN = 12'(PADDLE_W - 1);

  state_t      state, state_nx;
  logic [10:0] bh, bv, bh_nx, bv_nx;
  logic        dh, dv, dh_nx, dv_nx;
  logic [1:0]  lives_q, lives_nx;
  logic        hit, hit_nx, over, over_nx, won, won_nx;

  logic        in_region, on_paddle;
  logic [2:0]  col;
  logic [1:0]  row;
  logic [4:0]  idx;
  logic [11:0] pad_lo, pad_hi;

  // Brick cell under the ball; row is counted from the top of the screen.
  assign in_region = (bh >= 11'd64) && (bh <= 11'd575) && (bv >= 11'd321) && (bv <= 11'd416);
  assign col       = 3'((bh - 11'd64) >> 6);
  assign row       = 2'((11'd416 - bv) >> 5);
  assign idx       = {row, col};

  // Widened so a paddle near the right edge cannot wrap its span.
  assign pad_lo    = {1'b0, bus.paddle_h};
  assign pad_hi    = pad_lo + PAD_SPAN;
  assign on_paddle = ({1'b0, bh} >= pad_lo) && ({1'b0, bh} <= pad_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SERVE;
      bh      <= 11'd320;
      bv      <= REST_V;
      dh      <= 1'b1;
      dv      <= 1'b1;
      lives_q <= 2'(START_LIVES);
      hit     <= 1'b0;
      over    <= 1'b0;
      won     <= 1'b0;
    end else begin
      state   <= state_nx;
      bh      <= bh_nx;
      bv      <= bv_nx;
      dh      <= dh_nx;
      dv      <= dv_nx;
      lives_q <= lives_nx;
      hit     <= hit_nx;
      over    <= over_nx;
      won     <= won_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bh_nx    = bh;
    bv_nx    = bv;
    dh_nx    = dh;
    dv_nx    = dv;
    lives_nx = lives_q;
    hit_nx   = 1'b0;
    over_nx  = over;
    won_nx   = won;
    case (state)
      SERVE: begin
        bh_nx = bus.paddle_h + HALF_W;
        bv_nx = REST_V;
        dh_nx = 1'b1;
        dv_nx = 1'b1;
        if (bus.tick && bus.launch) state_nx = MOVE;
      end
      MOVE: begin
        if (bus.tick) begin
          // A miss freezes the ball where it fell; otherwise the axes update independently.
          if (!dv && bv == 11'd0) begin
            state_nx = LOST;
          end else begin
            if (dh && bh == 11'd639) begin
              dh_nx = 1'b0;
              bh_nx = 11'd638;
            end else if (!dh && bh == 11'd0) begin
              dh_nx = 1'b1;
              bh_nx = 11'd1;
            end else begin
              bh_nx = dh ? bh + 11'd1 : bh - 11'd1;
            end
            if (dv && bv == 11'd479) begin
              dv_nx = 1'b0;
              bv_nx = 11'd478;
            end else if (!dv && bv == REST_V && on_paddle) begin
              dv_nx = 1'b1;
              bv_nx = LIFT_V;
            end else begin
              bv_nx = dv ? bv + 11'd1 : bv - 11'd1;
            end
            state_nx = CHECK;
          end
        end
      end
      CHECK: begin
        if (bus.arr == 24'd0) begin
          state_nx = WIN;
          won_nx   = 1'b1;
        end else begin
          if (in_region && bus.arr[idx]) begin
            dv_nx  = ~dv;
            hit_nx = 1'b1;
          end
          state_nx = MOVE;
        end
      end
      LOST: begin
        if (lives_q <= 2'd1) begin
          lives_nx = 2'd0;
          over_nx  = 1'b1;
          state_nx = GAMEOVER;
        end else begin
          lives_nx = lives_q - 2'd1;
          state_nx = SERVE;
        end
      end
      GAMEOVER, WIN: begin
      end
      default: state_nx = SERVE;
    endcase
  end

  assign bus.bh_pos    = bh;
  assign bus.bv_pos    = bv;
  assign bus.bdirect_h = dh;
  assign bus.bdirect_v = dv;
  assign bus.lives     = lives_q;
  assign bus.brick_hit = hit;
  assign bus.game_over = over;
  assign bus.win       = won;

endmodule
